// File: rtl/dadda_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the Dadda multiplier
// final carry-propagate stage.
package dadda_pkg;

  localparam int N_DEF     = 8;
  localparam int CHUNK_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Number of add cycles needed to cover a 2N-bit row in CHUNK-bit slices.
  function automatic int nseg(input int n, input int chunk);
    return (2 * n) / chunk;
  endfunction

  function automatic bit chunk_divides(input int n, input int chunk);
    return ((2 * n) % chunk) == 0;
  endfunction

endpackage

// File: rtl/cpa_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from fa_cell instances;
// time-shared across all segments of the final add.
module cpa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;
  assign co   = c[CHUNK];

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/fa_cell.sv
// Single-bit full adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/dadda_final_cpa.sv
// Multi-cycle final adder of the Dadda tree: adds the two reduced rows CHUNK
// bits per cycle with a registered inter-segment carry, valid/ready on both sides.
module dadda_final_cpa
  import dadda_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] row_a,
  input  logic [2*N-1:0] row_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           cout,
  output logic           busy
);

  localparam int W    = 2 * N;
  localparam int NSEG = nseg(N, CHUNK);
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  if (!chunk_divides(N, CHUNK)) begin : g_bad_chunk
    $error("dadda_final_cpa: CHUNK must divide 2*N");
  end

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    ra, rb;
  logic [CHUNK-1:0] seg_a, seg_b, seg_s;
  logic            seg_co;
  logic            accept;
  logic            last_seg;

  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == S_ADD);
  assign last_seg = (idx == IW'(NSEG - 1));

  // Only one segment is live per cycle, so the adder input is a plain slice mux.
  assign seg_a = ra[int'(idx)*CHUNK +: CHUNK];
  assign seg_b = rb[int'(idx)*CHUNK +: CHUNK];

  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (seg_a),
    .b  (seg_b),
    .ci (carry),
    .s  (seg_s),
    .co (seg_co)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      product   <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ra    <= row_a;
            rb    <= row_b;
            carry <= 1'b0;
            idx   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          product[int'(idx)*CHUNK +: CHUNK] <= seg_s;
          carry                             <= seg_co;
          if (last_seg) begin
            cout      <= seg_co;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              ra    <= row_a;
              rb    <= row_b;
              carry <= 1'b0;
              idx   <= '0;
              state <= S_ADD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_final_cpa.sv
// Self-checking bench for dadda_final_cpa: directed cases plus a randomised
// stream checked against a queue of expected sums.
module tb_dadda_final_cpa;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] row_a = '0;
  logic [W-1:0] row_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] product;
  logic         cout;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] p;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dadda_final_cpa #(.N(N), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_a     (row_a),
    .row_b     (row_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present rows and hold in_valid until the accepting edge has passed.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int cnt = 0;
    in_valid = 1'b1;
    row_a    = a;
    row_b    = b;
    #1;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt == 50) check("send_timeout", 32'(cnt), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    row_a    = W'($urandom);
    row_b    = W'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int sent, got, cyc;
    exp_t e;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product",   32'(product),   32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: carry across a segment boundary, latency 4
    send(16'h00FF, 16'h0001);
    check("t1_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    check("t1_latency", 32'(lat),     32'd4);
    check("t1_product", 32'(product), 32'h0100);
    check("t1_cout",    32'(cout),    32'd0);
    release_out();
    check("t1_cleared",  32'(out_valid), 32'd0);
    check("t1_in_ready", 32'(in_ready),  32'd1);

    // 2: full ripple through all segments, overflow
    send(16'hFFFF, 16'h0001);
    wait_valid(lat);
    check("t2_latency", 32'(lat),     32'd4);
    check("t2_product", 32'(product), 32'h0000);
    check("t2_cout",    32'(cout),    32'd1);
    release_out();

    // 3: output stalled for 10 cycles with new rows pending
    send(16'hFE00, 16'h0001);
    wait_valid(lat);
    in_valid = 1'b1;
    row_a    = 16'hAAAA;
    row_b    = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_product",   32'(product),   32'hFE01);
      check("t3_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end

    // 4: back-to-back output and input handshake on the same edge
    row_a     = 16'h1234;
    row_b     = 16'h4321;
    out_ready = 1'b1;
    #1;
    check("t4_in_ready",  32'(in_ready),  32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_product0",  32'(product),   32'hFE01);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t4_drop_valid", 32'(out_valid), 32'd0);
    check("t4_busy",       32'(busy),      32'd1);
    wait_valid(lat);
    check("t4_latency", 32'(lat),     32'd4);
    check("t4_product", 32'(product), 32'h5555);
    check("t4_cout",    32'(cout),    32'd0);
    release_out();

    // 5: reset in the middle of ADD, then a clean operation
    send(16'h1111, 16'h2222);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_product",   32'(product),   32'd0);
    check("t5_busy",      32'(busy),      32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_output", 32'(out_valid), 32'd0);
    send(16'hABCD, 16'h1234);
    wait_valid(lat);
    check("t5_latency", 32'(lat),     32'd4);
    check("t5_product", 32'(product), 32'hBE01);
    check("t5_cout",    32'(cout),    32'd0);
    release_out();

    // 6: random stream with stalls on both sides
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 1000 && cyc < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 1000) && ($urandom_range(0, 2) != 0);
      row_a     = W'($urandom);
      row_b     = W'($urandom);
      #1;
      if (in_valid && in_ready) begin
        e.p = row_a + row_b;
        e.c = ({1'b0, row_a} + {1'b0, row_b}) >> W;
        exp_q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_output", 32'(got), 32'(sent));
        end else begin
          e = exp_q.pop_front();
          check("rand_product", 32'(product), 32'(e.p));
          check("rand_cout",    32'(cout),    32'(e.c));
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_received", 32'(got), 32'd1000);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
